// File: rtl/addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : addsub_rr_scheduler
// Brief   : Round-robin sharing of one W-bit add/subtract datapath among N
//           requesters. Optional signed-overflow flag via ADDSUB_OVF_FLAG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_rr_scheduler #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  input  logic [N-1:0]         req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_cout
`ifdef ADDSUB_OVF_FLAG_EN
  ,
  output logic                 rsp_ovf
`endif
);

  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_sub;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic [W-1:0]   w_bx;
  logic [W:0]     w_sum;

  // Rotating priority search starting at r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % N);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // Subtract is a + ~b + 1; the carry-in rides on the sub bit.
  assign w_bx  = r_b ^ {W{r_sub}};
  assign w_sum = {1'b0, r_a} + {1'b0, w_bx} + {{W{1'b0}}, r_sub};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
`ifdef ADDSUB_OVF_FLAG_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a     <= req_a[w_win*W +: W];
            r_b     <= req_b[w_win*W +: W];
            r_sub   <= req_sub[w_win];
            r_id    <= w_win;
            r_ptr   <= (w_win == IDW'(N-1)) ? '0 : w_win + IDW'(1);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result <= w_sum[W-1:0];
          rsp_cout   <= w_sum[W];
          rsp_id     <= r_id;
`ifdef ADDSUB_OVF_FLAG_EN
          rsp_ovf    <= (r_a[W-1] == w_bx[W-1]) && (w_sum[W-1] != r_a[W-1]);
`endif
          rsp_valid  <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_rr_scheduler
// Brief   : Directed + random checks of addsub_rr_scheduler against a
//           behavioural model (arbitration order and integer arithmetic).
// Revision: 1.0 - initial release
// ============================================================================
module tb_addsub_rr_scheduler;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_cout;
`ifdef ADDSUB_OVF_FLAG_EN
  logic           rsp_ovf;
`endif

  always #5 clk = ~clk;

  addsub_rr_scheduler #(.N(N), .W(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout)
`ifdef ADDSUB_OVF_FLAG_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int m_ptr  = 0;
  int grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input int s);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_sub[i]      = s[0];
  endtask

  // One arbitration round: present mask, follow the operation to completion,
  // holding the response for bp cycles of backpressure.
  task automatic op(input logic [N-1:0] mask, input int bp);
    int win, a, b, s, full, exp_res, exp_cout, sa, sb, sr, exp_ovf, j;
    win = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (win < 0 && mask[j]) win = j;
    end
    req_valid = mask;
    rsp_ready = (bp == 0);
    #1;
    if (win < 0) begin
      chk("idle_ready", 32'(req_ready), 32'd0);
      cyc();
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      return;
    end
    chk("grant", 32'(req_ready), 32'd1 << win);
    a = int'(req_a[win*W +: W]);
    b = int'(req_b[win*W +: W]);
    s = int'(req_sub[win]);
    if (s != 0) begin
      full     = a - b;
      exp_cout = (a >= b) ? 1 : 0;
    end else begin
      full     = a + b;
      exp_cout = (full >= (1 << W)) ? 1 : 0;
    end
    exp_res = (full + (1 << W)) % (1 << W);
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sr = (s != 0) ? sa - sb : sa + sb;
    exp_ovf = (sr < -(1 << (W-1)) || sr >= (1 << (W-1))) ? 1 : 0;
    grants.push_back(win);
    m_ptr = (win + 1) % N;

    cyc();
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_ready", 32'(req_ready), 32'd0);
    cyc();
    for (int c = 0; c <= bp; c++) begin
      if (c > 0) cyc();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(win));
      chk("rsp_result", 32'(rsp_result), 32'(exp_res));
      chk("rsp_cout", 32'(rsp_cout), 32'(exp_cout));
`ifdef ADDSUB_OVF_FLAG_EN
      chk("rsp_ovf", 32'(rsp_ovf), 32'(exp_ovf));
`endif
      chk("resp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    cyc();
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
`ifdef ADDSUB_OVF_FLAG_EN
    chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif
    rst_n     = 1'b1;
    req_valid = '0;
    m_ptr     = 0;
  endtask

  initial begin
    int exp_rr[5];
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    do_reset();

    // Directed add and subtract cases.
    set_op(0, 7, 5, 0);
    op(4'b0001, 0);
    chk("add_hex_c", 32'(rsp_result), 32'hC);
    set_op(2, 5, 7, 1);
    op(4'b0100, 0);
    chk("sub_hex_e", 32'(rsp_result), 32'hE);
    set_op(2, 7, 5, 1);
    op(4'b0100, 0);
    chk("sub_cout", 32'(rsp_cout), 32'd1);

    // Round-robin with every requester asserted.
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    repeat (5) op(4'b1111, 0);
    exp_rr = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(grants[k]), 32'(exp_rr[k]));

    // Backpressure with wraparound.
    set_op(1, 15, 1, 0);
    op(4'b0010, 5);

    // Reset while the operation is executing.
    set_op(2, 3, 4, 0);
    req_valid = 4'b0100;
    cyc();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    cyc();
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    m_ptr = 0;
    cyc();
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 4'b1010;
    #1;
    chk("postrst_grant1", 32'(req_ready), 32'd2);
    set_op(1, 9, 9, 1);
    set_op(3, 2, 2, 0);
    op(4'b1010, 0);

`ifdef ADDSUB_OVF_FLAG_EN
    set_op(0, 7, 1, 0);
    op(4'b0001, 0);
    chk("ovf_add", 32'(rsp_ovf), 32'd1);
    set_op(0, 8, 1, 1);
    op(4'b0001, 0);
    chk("ovf_sub", 32'(rsp_ovf), 32'd1);
    set_op(0, 3, 2, 0);
    op(4'b0001, 0);
    chk("ovf_none", 32'(rsp_ovf), 32'd0);
`endif

    // Randomised traffic, including idle rounds.
    repeat (60) begin
      for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      op(N'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
- Shares one W-bit adder/subtractor datapath between N requesters using round-robin arbitration.
- Each requester presents operands and an add/subtract select over a valid/ready handshake.
- The block captures the winning request, computes the result, and returns it with the requester ID over a valid/ready response channel.
- Sits between client blocks and the arithmetic datapath. It is the only block that drives the datapath operands and the carry-in/mode line.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 4, operand/result width in bits.
- IDW, localparam = $clog2(N), width of rsp_id.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  N  bit i: requester i has an operation pending.
- req_ready  output  N  bit i: request i accepted this cycle (one-hot or zero).
- req_a  input  N*W  requester i operand A in bits [i*W +: W].
- req_b  input  N*W  requester i operand B in bits [i*W +: W].
- req_sub  input  N  bit i: 1 = A-B, 0 = A+B.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of requester that issued the result.
- rsp_result  output  W  sum/difference, modulo 2^W.
- rsp_cout  output  1  datapath carry-out (for subtract: 1 = no borrow).

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM -> IDLE; rr pointer -> 0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0.
  - Captured operand registers -> 0.
  - req_ready=0 while rst_n=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ..., ptr+N-1 (mod N).
  - If a winner exists: req_ready[winner]=1 combinationally in that cycle (all other bits 0). On the clock edge, latch a, b, sub and the winner ID, set ptr <= (winner+1) mod N, and go to EXEC.
  - If no winner: req_ready=0 and the FSM stays in IDLE.
- EXEC (exactly one cycle):
  - Compute result = a + (b XOR {W{sub}}) + sub, (W+1)-bit.
  - Register rsp_result = low W bits, rsp_cout = bit W, rsp_id = latched ID.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_valid and rsp_ready are both 1 at the edge: rsp_valid <= 0 and go to IDLE.
  - rsp_ready is ignored outside RESP.
- req_ready is 0 in EXEC and RESP; no request is accepted while an operation is in flight.
- Latency: request accepted at edge T, rsp_valid=1 from T+1 (i.e. visible in the cycle after EXEC = cycle 2 after accept cycle). Minimum issue interval is 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready=1).
- Requester contract: hold req_a/req_b/req_sub stable while req_valid=1 and req_ready[i]=0. Dropping req_valid before grant is legal; no state change results.
- Fairness: a continuously asserted requester is granted within N accepts.
- Overflow/wrap: the result wraps modulo 2^W. No saturation.
- Reset during EXEC or RESP: the in-flight operation is discarded, no response is produced, and ptr returns to 0.
- The same requester may be re-granted immediately if it is the only one valid.

Optional Feature:
- Macro: ADDSUB_OVF_FLAG_EN.
- Defined:
  - Extra output port rsp_ovf (output, 1 bit), registered in EXEC alongside the result and reset to 0.
  - rsp_ovf = two's-complement signed overflow: (a[W-1] == b'[W-1]) && (result[W-1] != a[W-1]), where b' = b XOR {W{sub}}.
- Undefined:
  - Port and logic are absent; all other behaviour is identical.

Test Plan:
- Add: requester 0 only, a=7, b=5, sub=0 -> req_ready[0] pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=4'hC, rsp_cout=0.
- Subtract: requester 2, a=5, b=7, sub=1 -> rsp_result=4'hE, rsp_cout=0, rsp_id=2. Then a=7, b=5, sub=1 -> rsp_result=4'h2, rsp_cout=1.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1, N=4 -> grant order 0,1,2,3,0; each rsp_id matches its grant; no req_ready overlap.
- Backpressure: a=15, b=1, sub=0 with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_result=0 and rsp_cout=1 stay stable; all req_ready=0 throughout; response completes when rsp_ready=1.
- Reset mid-op: assert rst_n=0 in EXEC -> no rsp_valid; after release, requesters 1 and 3 valid -> requester 1 granted first (ptr=0).
- ADDSUB_OVF_FLAG_EN: a=7, b=1, sub=0 -> rsp_result=4'h8, rsp_ovf=1. a=8, b=1, sub=1 -> rsp_result=4'h7, rsp_ovf=1. a=3, b=2, sub=0 -> rsp_ovf=0.
